// File: rtl/crc_error_monitor.sv
// Supervises the asynchronous readback CRC error flag: synchronizes and filters it, counts
// qualified events, raises a request/acknowledge interrupt and a sticky fatal indication.
module crc_error_monitor #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4,
  parameter int CNT_W         = 8,
  parameter int FATAL_THRESH  = 3
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             crc_error_in,
  output logic             irq,
  input  logic             irq_ack,
  input  logic             clr_count,
  output logic [CNT_W-1:0] err_count,
  output logic             fatal,
  output logic [2:0]       state
);

  localparam int FW = (FILTER_CYCLES < 2) ? 1 : $clog2(FILTER_CYCLES + 1);
  localparam logic [FW-1:0]    FC_LAST  = FW'(FILTER_CYCLES - 1);
  localparam logic [FW-1:0]    FC_ONE   = FW'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] THRESH   = CNT_W'(FATAL_THRESH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    QUAL   = 2'd1,
    REPORT = 2'd2,
    HOLD   = 2'd3
  } st_t;

  st_t                    st, st_nxt;
  logic [SYNC_STAGES-1:0] sync_p;
  logic                   crc_s;
  logic [FW-1:0]          fcnt, fcnt_nxt;
  logic                   qualify;
  logic                   irq_nxt;

  // Stage: flag synchronizer chain
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) sync_p <= '0;
    else          sync_p <= {sync_p[SYNC_STAGES-2:0], crc_error_in};
  end

  assign crc_s = sync_p[SYNC_STAGES-1];

  // Stage: FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) st <= IDLE;
    else          st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    if (!enable) begin
      st_nxt = IDLE;
    end else begin
      case (st)
        IDLE:    if (crc_s) st_nxt = (FILTER_CYCLES == 1) ? REPORT : QUAL;
        QUAL:    if (!crc_s) st_nxt = IDLE;
                 else if (fcnt == FC_LAST) st_nxt = REPORT;
        REPORT:  if (irq_ack) st_nxt = HOLD;
        HOLD:    if (!crc_s) st_nxt = IDLE;
        default: st_nxt = IDLE;
      endcase
    end
  end

  // An event is counted exactly on the edge that enters REPORT
  always_comb begin
    qualify  = (st_nxt == REPORT) && (st != REPORT);
    irq_nxt  = (st_nxt == REPORT);
    fcnt_nxt = '0;
    if (st_nxt == QUAL) fcnt_nxt = (st == IDLE) ? FC_ONE : fcnt + FC_ONE;
  end

  // Stage: filter counter, interrupt, event counter and fatal flag
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fcnt      <= '0;
      irq       <= 1'b0;
      err_count <= '0;
      fatal     <= 1'b0;
    end else begin
      fcnt <= fcnt_nxt;
      irq  <= irq_nxt;
      if (clr_count)                               err_count <= CNT_W'(qualify);
      else if (qualify && (err_count != CNT_MAX))  err_count <= err_count + 1'b1;
      fatal <= clr_count ? 1'b0 : (fatal | (err_count >= THRESH));
    end
  end

  assign state = {1'b0, st};

endmodule
